// File: rtl/stopwatch_pkg.sv
// Shared widths, default field limits and mode encoding for the stopwatch core.
package stopwatch_pkg;

   localparam int BCD_W       = 4;
   localparam int MIN_MAX_DEF = 59;
   localparam int SEC_MAX_DEF = 59;

   typedef enum logic [1:0] {
      MODE_RUN    = 2'd0,
      MODE_PAUSED = 2'd1,
      MODE_ADJUST = 2'd2
   } mode_t;

endpackage

// File: rtl/stopwatch_core_bcd2_counter.sv
// Two-digit BCD counter that wraps from MAX to 00 and flags the wrapping increment.
module bcd2_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX = SEC_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             wrap
);

   localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX / 10);
   localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX % 10);

   logic at_max;

   assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
   assign wrap   = inc & at_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens <= '0;
         ones <= '0;
      end else if (clr) begin
         tens <= '0;
         ones <= '0;
      end else if (inc) begin
         // The field limit wins over the ordinary ones-digit carry.
         if (at_max) begin
            tens <= '0;
            ones <= '0;
         end else if (ones == BCD_W'(9)) begin
            ones <= '0;
            tens <= tens + BCD_W'(1);
         end else begin
            ones <= ones + BCD_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch time base: run/pause/adjust control driving two BCD field counters.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX = MIN_MAX_DEF,
   parameter int SEC_MAX = SEC_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PAUSE,
   input  logic             RESET,
   input  logic             ADJ,
   input  logic             SEL,
   input  logic             tick_1hz,
   input  logic             tick_adj,
   output logic [BCD_W-1:0] min_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic             paused,
   output logic             blink_min,
   output logic             blink_sec
);

   mode_t mode;
   logic  pause_prev;
   logic  pause_rise;
   logic  sec_inc;
   logic  min_inc;
   logic  sec_wrap;
   logic  min_wrap;

   always_comb begin
      mode = MODE_RUN;
      if (ADJ)
         mode = MODE_ADJUST;
      else if (paused)
         mode = MODE_PAUSED;
   end

   assign pause_rise = PAUSE & ~pause_prev;

   // pause_prev keeps sampling during RESET so a held press cannot toggle on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_prev <= 1'b0;
         paused     <= 1'b0;
      end else begin
         pause_prev <= PAUSE;
         if (RESET)
            paused <= 1'b0;
         else if (pause_rise)
            paused <= ~paused;
      end
   end

   assign sec_inc = ((mode == MODE_RUN) & tick_1hz)
                  | ((mode == MODE_ADJUST) & SEL & tick_adj);
   assign min_inc = ((mode == MODE_RUN) & tick_1hz & sec_wrap)
                  | ((mode == MODE_ADJUST) & ~SEL & tick_adj);

   bcd2_counter #(.MAX(SEC_MAX)) u_seconds (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (RESET),
      .inc   (sec_inc),
      .tens  (sec_tens),
      .ones  (sec_ones),
      .wrap  (sec_wrap)
   );

   bcd2_counter #(.MAX(MIN_MAX)) u_minutes (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (RESET),
      .inc   (min_inc),
      .tens  (min_tens),
      .ones  (min_ones),
      .wrap  (min_wrap)
   );

   assign blink_min = ADJ & ~SEL;
   assign blink_sec = ADJ & SEL;

   // Minutes wrap has no consumer; fold it into nothing observable.
   logic unused_ok;
   assign unused_ok = min_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with an expected-value queue checked after each edge.
module tb_stopwatch_core;

   logic       clk;
   logic       rst_n;
   logic       PAUSE;
   logic       RESET;
   logic       ADJ;
   logic       SEL;
   logic       tick_1hz;
   logic       tick_adj;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       paused;
   logic       blink_min;
   logic       blink_sec;

   typedef struct {
      string       tag;
      logic [15:0] digits;
      logic        p;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   stopwatch_core #(.MIN_MAX(59), .SEC_MAX(59)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .PAUSE     (PAUSE),
      .RESET     (RESET),
      .ADJ       (ADJ),
      .SEL       (SEL),
      .tick_1hz  (tick_1hz),
      .tick_adj  (tick_adj),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .paused    (paused),
      .blink_min (blink_min),
      .blink_sec (blink_sec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] bcd(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic expect_state(input string tag, input int mm, input int ss, input logic p);
      exp_t e;
      e.tag    = tag;
      e.digits = bcd(mm, ss);
      e.p      = p;
      sb.push_back(e);
   endtask

   task automatic compare_next();
      exp_t        e;
      logic [15:0] obs;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty: observed no expected entry, required one");
         return;
      end
      e   = sb.pop_front();
      obs = {min_tens, min_ones, sec_tens, sec_ones};
      assert (obs === e.digits) else begin
         n_bad++;
         $error("FAIL %s digits: observed %h required %h", e.tag, obs, e.digits);
      end
      n_cmp++;
      assert (paused === e.p) else begin
         n_bad++;
         $error("FAIL %s paused: observed %b required %b", e.tag, paused, e.p);
      end
      $display("chk %-14s mmss=%h paused=%b", e.tag, obs, paused);
   endtask

   task automatic check_blink(input string tag, input logic bm, input logic bs);
      n_cmp++;
      assert ({blink_min, blink_sec} === {bm, bs}) else begin
         n_bad++;
         $error("FAIL %s blink: observed %b%b required %b%b", tag, blink_min, blink_sec, bm, bs);
      end
      $display("chk %-14s blink_min=%b blink_sec=%b", tag, blink_min, blink_sec);
   endtask

   // One clock edge with the given tick pulses; outputs sampled 1 time unit later.
   task automatic step(input logic t1, input logic ta);
      tick_1hz = t1;
      tick_adj = ta;
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
      tick_adj = 1'b0;
   endtask

   task automatic step_chk(input string tag, input logic t1, input logic ta,
                           input int mm, input int ss, input logic p);
      expect_state(tag, mm, ss, p);
      step(t1, ta);
      compare_next();
   endtask

   // Reach a count from 00:00 purely through the adjust path.
   task automatic preset(input int mm, input int ss);
      RESET = 1'b1;
      step(1'b0, 1'b0);
      RESET = 1'b0;
      ADJ   = 1'b1;
      SEL   = 1'b0;
      repeat (mm) step(1'b0, 1'b1);
      SEL = 1'b1;
      repeat (ss) step(1'b0, 1'b1);
      ADJ = 1'b0;
      SEL = 1'b0;
      expect_state("preset", mm, ss, 1'b0);
      compare_next();
   endtask

   initial begin
      rst_n    = 1'b0;
      PAUSE    = 1'b0;
      RESET    = 1'b0;
      ADJ      = 1'b0;
      SEL      = 1'b0;
      tick_1hz = 1'b0;
      tick_adj = 1'b0;
      #2;
      expect_state("reset_state", 0, 0, 1'b0);
      compare_next();
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset from a paused 12:34.
      preset(12, 34);
      PAUSE = 1'b1;
      step_chk("pause_1234", 1'b0, 1'b0, 12, 34, 1'b1);
      PAUSE = 1'b0;
      step_chk("hold_1234", 1'b1, 1'b0, 12, 34, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expect_state("async_rst", 0, 0, 1'b0);
      compare_next();
      @(negedge clk);
      rst_n = 1'b1;
      step_chk("post_rst_tick", 1'b1, 1'b0, 0, 1, 1'b0);

      // Run-mode carries and full wrap.
      preset(0, 58);
      step_chk("run_0059", 1'b1, 1'b0, 0, 59, 1'b0);
      step_chk("run_carry", 1'b1, 1'b0, 1, 0, 1'b0);
      step_chk("run_adj_ign", 1'b0, 1'b1, 1, 0, 1'b0);
      preset(59, 59);
      step_chk("run_wrap", 1'b1, 1'b0, 0, 0, 1'b0);

      // Held pause toggles exactly once; ticks frozen while paused.
      preset(3, 7);
      PAUSE = 1'b1;
      step_chk("pause_rise", 1'b0, 1'b0, 3, 7, 1'b1);
      for (int i = 0; i < 9; i++)
         step_chk("pause_held", i[0] ? 1'b0 : 1'b1, 1'b1, 3, 7, 1'b1);
      PAUSE = 1'b0;
      step_chk("pause_rel", 1'b1, 1'b0, 3, 7, 1'b1);
      PAUSE = 1'b1;
      step_chk("unpause", 1'b0, 1'b0, 3, 7, 1'b0);
      PAUSE = 1'b0;
      step_chk("resume_tick", 1'b1, 1'b0, 3, 8, 1'b0);

      // Adjust seconds and minutes: wrap without carry, 1 Hz ignored.
      preset(5, 59);
      ADJ = 1'b1;
      SEL = 1'b1;
      #1;
      check_blink("blink_sec", 1'b0, 1'b1);
      step_chk("adj_sec_wrap", 1'b0, 1'b1, 5, 0, 1'b0);
      step_chk("adj_1hz_ign", 1'b1, 1'b0, 5, 0, 1'b0);
      preset(59, 10);
      ADJ = 1'b1;
      SEL = 1'b0;
      #1;
      check_blink("blink_min", 1'b1, 1'b0);
      step_chk("adj_min_wrap", 1'b0, 1'b1, 0, 10, 1'b0);
      ADJ = 1'b0;
      #1;
      check_blink("blink_off", 1'b0, 1'b0);

      // Both ticks in one cycle under adjust: a single increment.
      preset(7, 42);
      ADJ = 1'b1;
      SEL = 1'b1;
      step_chk("adj_both_ticks", 1'b1, 1'b1, 7, 43, 1'b0);
      ADJ = 1'b0;
      SEL = 1'b0;

      // Synchronous RESET overrides pause edge and ticks; held press does not toggle after.
      preset(22, 22);
      PAUSE = 1'b1;
      step_chk("pause_2222", 1'b0, 1'b0, 22, 22, 1'b1);
      PAUSE = 1'b0;
      step_chk("paused_2222", 1'b0, 1'b0, 22, 22, 1'b1);
      PAUSE = 1'b1;
      RESET = 1'b1;
      step_chk("sync_reset", 1'b1, 1'b0, 0, 0, 1'b0);
      step_chk("reset_held", 1'b1, 1'b1, 0, 0, 1'b0);
      RESET = 1'b0;
      step_chk("reset_rel", 1'b0, 1'b0, 0, 0, 1'b0);
      step_chk("rel_tick", 1'b1, 1'b0, 0, 1, 1'b0);
      PAUSE = 1'b0;
      step(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Time-keeping core of the stopwatch. Consumes the debounced PAUSE, RESET, ADJ and SEL controls, plus 1 Hz and 2 Hz single-cycle tick enables from the clock divider. Maintains an MM:SS BCD count with run, pause and adjust behaviour, and drives the seven-segment display mux with four digits and two blink flags.

Parameters:
MIN_MAX, 59, highest minutes value before wrap to 00 (BCD-legal, 9..99)
SEC_MAX, 59, highest seconds value before wrap to 00 (BCD-legal, 9..99)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
PAUSE  in  1  debounced pause button, level
RESET  in  1  debounced reset button, level, synchronous clear
ADJ  in  1  debounced adjust switch; 1 = adjust mode
SEL  in  1  debounced select switch; 0 = minutes, 1 = seconds
tick_1hz  in  1  one-clk pulse per second
tick_adj  in  1  one-clk pulse at 2 Hz
min_tens  out  4  BCD minutes tens
min_ones  out  4  BCD minutes ones
sec_tens  out  4  BCD seconds tens
sec_ones  out  4  BCD seconds ones
paused  out  1  registered pause state
blink_min  out  1  ADJ & ~SEL (combinational)
blink_sec  out  1  ADJ & SEL (combinational)

Behaviour:
- Reset (rst_n low, async): all digits 0, paused 0, pause_prev 0. On release the core is in RUN at 00:00.
- Effective mode, evaluated each clk: ADJ=1 gives ADJUST. Otherwise paused=1 gives PAUSED, else RUN.
- Priority per clk edge:
  - RESET first.
  - Then the pause toggle.
  - Then the count update.
- All outputs except the blink flags are registered. An event sampled at edge N is visible after edge N.
- RESET=1 (synchronous, level):
  - Digits cleared to 00:00 and paused cleared to 0, every cycle it is held.
  - tick_1hz and tick_adj are ignored.
  - pause_prev still samples PAUSE, so a press held across a RESET release does not toggle.
- Pause edge:
  - pause_prev registers PAUSE each cycle.
  - Rising edge (PAUSE=1, pause_prev=0) with RESET=0 toggles paused.
  - Holding PAUSE produces exactly one toggle.
  - Toggling is allowed in any mode, including ADJUST.
- RUN:
  - tick_1hz increments seconds.
  - Seconds at SEC_MAX wrap to 00 and carry +1 into minutes.
  - Minutes at MIN_MAX wrap to 00 (59:59 goes to 00:00).
  - tick_adj is ignored.
- PAUSED: count frozen; both ticks ignored.
- ADJUST (whether or not paused):
  - tick_1hz is ignored.
  - tick_adj increments only the selected field (SEL=0 minutes, SEL=1 seconds).
  - The field wraps MAX to 00 with no carry; the other field is unchanged.
- tick_1hz and tick_adj in the same cycle: only the mode-relevant tick acts, giving at most one increment per cycle.
- ADJ or SEL changing mid-operation takes effect on the next edge. Counts are never cleared by a mode change.
- BCD increment rule:
  - Ones digit 9 goes to 0 and carries into tens.
  - The field equal to MAX goes to 00 regardless of digit position.
  - Digits never leave 0..9.

Decomposition:
- Package stopwatch_pkg holds:
  - BCD_W = 4
  - default MIN_MAX / SEC_MAX
  - mode encoding: RUN, PAUSED, ADJUST (2 bits)
- One sub-module, bcd2_counter:
  - Two-digit BCD counter with parameter MAX.
  - Inputs: clk, rst_n, clr, inc.
  - Outputs: tens, ones, wrap (combinational, inc & value==MAX).
- Instantiated twice:
  - seconds: inc = RUN&tick_1hz | ADJUST&SEL&tick_adj
  - minutes: inc = RUN&tick_1hz&sec_wrap | ADJUST&~SEL&tick_adj
- Pause edge detect and mode decode stay in the top.

Test Plan:
- Count at 12:34 in RUN, assert rst_n low between edges -> outputs 00:00 and paused=0 immediately, before the next clk edge; after release, one tick_1hz -> 00:01.
- RUN from 00:58, two tick_1hz -> 00:59 then 01:00; preset 59:59, one tick_1hz -> 00:00.
- PAUSE held 10 cycles with tick_1hz pulses at 03:07 -> paused=1 one cycle after the rise, count stays 03:07; release, press again -> paused=0, next tick -> 03:08.
- ADJ=1, SEL=1 at 05:59:
  - tick_adj -> 05:00 (no carry); tick_1hz -> unchanged.
  - SEL=0 at 59:10, tick_adj -> 00:10.
  - blink_sec/blink_min follow SEL.
- ADJ=1 at 07:42, tick_1hz and tick_adj in the same cycle with SEL=1 -> 07:43 exactly.
- RESET=1 in the same cycle as a PAUSE rising edge and tick_1hz at 22:22, paused=1 -> 00:00, paused=0; PAUSE still held at RESET release -> no toggle.
